// File: rtl/tim_edge_sum_product_accum.sv
// Burst accumulator downstream of the comb sum/product stage: gathers BURST_LEN
// (sum, product) pairs into two wide accumulators and presents the totals on a handshake.
module tim_edge_sum_product_accum #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ACC_W     = 20,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_sum,
    input  logic [DATA_W-1:0] in_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum_acc,
    output logic [ACC_W-1:0]  out_prod_acc,
    output logic              out_overflow,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StAccum = 2'd1;
    localparam logic [1:0] StHold  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_sum_q, acc_sum_d;
    logic [ACC_W-1:0] acc_prod_q, acc_prod_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic [CNT_W-1:0] cnt_inc;
    logic             last_pair;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W:0]   prod_ext;

    assign in_ready  = (state_q != StHold);
    assign out_valid = (state_q == StHold);
    assign busy      = (state_q != StIdle);
    assign accept    = in_valid && in_ready;

    assign cnt_inc   = cnt_q + 1'b1;
    assign last_pair = (cnt_inc == CNT_W'(BURST_LEN));

    // Bit ACC_W of each widened sum is the carry out of the accumulator.
    assign sum_ext  = {1'b0, acc_sum_q} + (ACC_W + 1)'(in_sum);
    assign prod_ext = {1'b0, acc_prod_q} + (ACC_W + 1)'(in_product);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_sum_d  = acc_sum_q;
        acc_prod_d = acc_prod_q;
        ovf_d      = ovf_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    acc_sum_d  = ACC_W'(in_sum);
                    acc_prod_d = ACC_W'(in_product);
                    ovf_d      = 1'b0;
                    cnt_d      = CNT_W'(1);
                    state_d    = (BURST_LEN == 1) ? StHold : StAccum;
                end
            end
            StAccum: begin
                if (accept) begin
                    acc_sum_d  = sum_ext[ACC_W-1:0];
                    acc_prod_d = prod_ext[ACC_W-1:0];
                    ovf_d      = ovf_q | sum_ext[ACC_W] | prod_ext[ACC_W];
                    cnt_d      = cnt_inc;
                    if (last_pair) begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                // Totals stay visible after release until the next burst starts.
                if (out_ready) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_sum_q  <= '0;
            acc_prod_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_sum_q  <= acc_sum_d;
            acc_prod_q <= acc_prod_d;
            ovf_q      <= ovf_d;
        end
    end

    assign out_sum_acc  = acc_sum_q;
    assign out_prod_acc = acc_prod_q;
    assign out_overflow = ovf_q;

endmodule

// File: doc/tim_edge_sum_product_accum.md
Name: tim_edge_sum_product_accum

Overview:
- Registered consumer stage that sits directly downstream of the combinational sum/product stage.
- Accepts one (sum, product) pair per valid/ready handshake and accumulates BURST_LEN pairs into two wide accumulators.
- Presents the burst totals on an output valid/ready handshake.
- Exercises clocked non-blocking logic next to the blocking-assignment comb stage for the timing-rule checks.

Parameters:
- DATA_W, 8, width of in_sum and in_product.
- ACC_W, 20, accumulator width. Must be >= DATA_W.
- BURST_LEN, 4, pairs per burst. Must be >= 1.
- CNT_W, $clog2(BURST_LEN+1), burst counter width (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream pair valid.
- in_ready  output  1  stage can accept a pair.
- in_sum  input  DATA_W  upstream sum, unsigned.
- in_product  input  DATA_W  upstream product, unsigned.
- out_valid  output  1  burst result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum_acc  output  ACC_W  accumulated sum.
- out_prod_acc  output  ACC_W  accumulated product.
- out_overflow  output  1  a carry out of ACC_W occurred during this burst.
- busy  output  1  state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, count=0, accumulators=0, out_overflow=0, out_valid=0, busy=0. in_ready=1 once rst deasserts.
- States: IDLE, ACCUM, HOLD.
- in_ready = (state != HOLD). It is combinational from state only and has no dependence on in_valid.
- out_valid = (state == HOLD).
- out_sum_acc, out_prod_acc and out_overflow are driven directly from registers. No combinational path from any input to any output.
- Accept = in_valid && in_ready.
- IDLE + accept:
  - acc_sum <= zero-extended in_sum; acc_prod <= zero-extended in_product; overflow <= 0; count <= 1.
  - Next state is HOLD if BURST_LEN==1, otherwise ACCUM.
- IDLE, no accept: all registers hold.
- ACCUM + accept:
  - acc_sum <= acc_sum + in_sum; acc_prod <= acc_prod + in_product; count <= count+1.
  - Additions are modulo 2^ACC_W (wrap-around).
  - overflow <= overflow | carry_sum | carry_prod, where each carry is bit ACC_W of the ACC_W+1-bit sum.
  - When count+1 == BURST_LEN, next state is HOLD.
- ACCUM, no accept: hold. Gaps in in_valid of any length are allowed and lose no data.
- HOLD:
  - Outputs stable while out_valid && !out_ready.
  - On out_ready: next state IDLE, count <= 0. Accumulators and overflow keep their values until the next IDLE accept overwrites them.
  - in_ready=0 in HOLD, so a pair offered during the out_ready cycle is not accepted.
- Latency: out_valid rises the cycle after the BURST_LEN-th accept. After an out_ready handshake, in_ready returns the following cycle.
- in_sum and in_product are sampled only on accept; their values at other times are don't-care.
- Reset mid-burst or mid-HOLD: everything clears immediately (asynchronous). The partial burst is discarded and no out_valid is produced for it.

Test Plan:
- BURST_LEN=4, back-to-back pairs (10,1),(20,2),(30,3),(40,4), out_ready=1 -> out_valid for exactly 1 cycle, starting the cycle after the 4th accept; out_sum_acc=100, out_prod_acc=10, out_overflow=0.
- Same stimulus with out_ready=0 for 5 cycles, then 1 -> out_valid and outputs stable for 6 cycles; in_ready=0 throughout HOLD; a pair offered in HOLD is not accepted.
- ACC_W=9, four pairs of (255,255) -> out_sum_acc=508, out_prod_acc=508, out_overflow=1. The next burst (1,1)x4 -> out_sum_acc=4, out_prod_acc=4, out_overflow=0.
- in_valid pattern 1,0,0,1,0,1,1 carrying sums 5,7,9,11 -> out_sum_acc=32, out_valid exactly once.
- Assert rst after 2 accepts -> busy=0 and accumulators=0 in the same cycle. Then 4 new pairs of (1,1) -> out_sum_acc=4, out_prod_acc=4.
- BURST_LEN=1, pairs (3,9),(4,16) with out_ready=1 -> two results, (3,9) then (4,16), each out_valid for 1 cycle.
